// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - parametrised valid/ready register pipeline with bubble collapse and flush
module pipe_reg_chain #(
    parameter int             WIDTH     = 8,
    parameter int             DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [WIDTH-1:0]             i_in_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_out_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_v_in;
    logic [DEPTH-1:0] w_v_nxt;
    logic [WIDTH-1:0] w_d_in [DEPTH];
    logic [OCC_W-1:0] w_occ_nxt;

    // Ready chain: a stage can move when any stage from it to the output is
    // empty, or the consumer takes the output word. Built as a running AND
    // of valids so there is no combinational self-reference on w_rdy.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        w_rdy    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & r_v[i];
            w_rdy[i] = i_out_ready | ~all_full;
        end
    end

    assign o_in_ready = w_rdy[0] & ~i_flush;

    // Incoming word for each stage: stage 0 from the producer, others from upstream
    always_comb begin
        w_v_in    = '0;
        w_v_in[0] = i_in_valid & o_in_ready;
        w_d_in[0] = i_in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_v_in[i] = r_v[i-1];
            w_d_in[i] = r_data[i-1];
        end
    end

    // Next valid vector and its popcount for the registered occupancy
    always_comb begin
        w_occ_nxt = '0;
        w_v_nxt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_v_nxt[i] = w_rdy[i] ? w_v_in[i] : r_v[i];
            w_occ_nxt  = w_occ_nxt + OCC_W'(w_v_nxt[i]);
        end
    end

    // Stage registers: reset and flush clear everything; data only captures valid words
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else begin
            r_v   <= w_v_nxt;
            r_occ <= w_occ_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i] && w_v_in[i]) begin
                    r_data[i] <= w_d_in[i];
                end
            end
        end
    end

    assign o_out_valid = r_v[DEPTH-1];
    assign o_out_data  = r_data[DEPTH-1];
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - scoreboard bench for pipe_reg_chain
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    logic       last_fi;
    int         peak;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_occupancy (occupancy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic fi, fo, fl, rs;
        logic [7:0] din, dout;
        #1;
        fi   = in_valid && in_ready;
        fo   = out_valid && out_ready;
        fl   = flush;
        rs   = reset;
        din  = in_data;
        dout = out_data;
        @(posedge clk);
        #1;
        last_fi = fi && !rs;
        if (rs) begin
            sb.delete();
        end else begin
            if (fo) begin
                if (sb.size() == 0) check_eq("sb_nonempty", 32'(sb.size()), 1);
                else                check_eq("out_data", dout, sb.pop_front());
            end
            if (fl)      sb.delete();
            else if (fi) sb.push_back(din);
        end
        check_eq("occupancy", occupancy, 32'(sb.size()));
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check_eq("drain_empty", 32'(sb.size()), 0);
        check_eq("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        // 1: reset held two cycles
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_out_data", out_data, 8'h00);

        // 2: back-to-back stream, latency DEPTH-1 after accept
        out_ready = 1'b1;
        peak = 0;
        in_valid = 1'b1;
        in_data = 8'h11; tick(); if (occupancy > peak) peak = occupancy;
        in_data = 8'h22; tick(); if (occupancy > peak) peak = occupancy;
        in_data = 8'h33; tick(); if (occupancy > peak) peak = occupancy;
        in_valid = 1'b0;
        check_eq("lat_not_yet", out_valid, 0);
        tick(); if (occupancy > peak) peak = occupancy;
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_data11", out_data, 8'h11);
        tick(); if (occupancy > peak) peak = occupancy;
        check_eq("seq_data22", out_data, 8'h22);
        tick(); if (occupancy > peak) peak = occupancy;
        check_eq("seq_data33", out_data, 8'h33);
        check_eq("occ_peak", peak, 3);
        drain();

        // 3: backpressure fill to DEPTH, then in-order release
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'hA0 + 8'(k);
            tick();
        end
        in_data = 8'hA4;
        #1;
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_occupancy", occupancy, 4);
        tick();
        check_eq("full_hold_a0", out_data, 8'hA0);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && !last_fi; n++) tick();
        check_eq("a4_accepted", last_fi, 1);
        drain();

        // 4: bubble collapse under stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'h02; tick();
        in_valid = 1'b0; tick(); tick();
        check_eq("bub_occupancy", occupancy, 2);
        check_eq("bub_in_ready", in_ready, 1);
        check_eq("bub_out_data", out_data, 8'h01);
        check_eq("bub_stage2", dut.r_data[2], 8'h02);
        drain();

        // 5: flush with words in flight and a word offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hC1 + 8'(k);
            tick();
        end
        in_data = 8'h55;
        flush = 1'b1;
        #1;
        check_eq("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_occupancy", occupancy, 0);
        check_eq("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("flush_no_55", out_valid, 0);
        end

        // 6: reset mid-stream with toggling out_ready, then restart
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'h60 + 8'(k);
            out_ready = k[0];
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_occupancy", occupancy, 0);
        check_eq("mid_rst_out_data", out_data, 8'h00);
        check_eq("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("restart_valid", out_valid, 1);
        check_eq("restart_data", out_data, 8'h77);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
